// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Brief   : Instruction fetch stage with credit-limited imem requests,
//           2-entry instruction buffer and registered decode-facing outputs.
// Revision: 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PC_plus_4,
    output logic        InstrValid
);

    logic [31:0] fpc_q, fpc_d;
    logic [1:0]  inflight_q, inflight_d;
    logic [1:0]  drop_q, drop_d;

    logic [31:0] pend_pc_q [2];
    logic        pend_wr_q, pend_rd_q;

    logic [31:0] buf_data_q [2];
    logic [31:0] buf_pc_q   [2];
    logic        buf_wr_q, buf_wr_d;
    logic        buf_rd_q, buf_rd_d;
    logic [1:0]  buf_cnt_q, buf_cnt_d;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic w_credit, w_issue, w_rsp, w_keep, w_pop;

    always_comb begin
        w_credit       = ({1'b0, inflight_q} + {1'b0, buf_cnt_q}) < 3'd2;
        imem_req_valid = !flush && w_credit;
        imem_req_addr  = fpc_q & 32'hFFFF_FFFC;
        w_issue        = imem_req_valid && imem_req_ready;
        // Responses with nothing outstanding (e.g. after reset) are ignored.
        w_rsp          = imem_rsp_valid && (inflight_q != 2'd0);
        w_keep         = w_rsp && !flush && (drop_q == 2'd0);
        w_pop          = !flush && !stall && (buf_cnt_q != 2'd0);
    end

    always_comb begin
        fpc_d      = fpc_q;
        inflight_d = inflight_q + {1'b0, w_issue} - {1'b0, w_rsp};
        drop_d     = drop_q;
        buf_cnt_d  = buf_cnt_q;
        buf_wr_d   = buf_wr_q;
        buf_rd_d   = buf_rd_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;

        if (flush) begin
            fpc_d     = redirect_pc & 32'hFFFF_FFFC;
            // Everything still outstanding is stale; a same-cycle response is discarded now.
            drop_d    = inflight_q - {1'b0, w_rsp};
            buf_cnt_d = 2'd0;
            buf_wr_d  = 1'b0;
            buf_rd_d  = 1'b0;
        end else begin
            if (w_issue) begin
                fpc_d = fpc_q + 32'd4;
            end
            if (w_rsp && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end
            buf_cnt_d = buf_cnt_q + {1'b0, w_keep} - {1'b0, w_pop};
            if (w_keep) begin
                buf_wr_d = ~buf_wr_q;
            end
            if (w_pop) begin
                buf_rd_d = ~buf_rd_q;
            end
        end

        if (flush) begin
            instr_d = NOP_INSTR;
            pc_d    = 32'd0;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end else if (stall) begin
            instr_d = instr_q;
        end else if (buf_cnt_q != 2'd0) begin
            instr_d = buf_data_q[buf_rd_q];
            pc_d    = buf_pc_q[buf_rd_q];
            pc4_d   = buf_pc_q[buf_rd_q] + 32'd4;
            valid_d = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            pc_d    = 32'd0;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q      <= RESET_PC;
            inflight_q <= 2'd0;
            drop_q     <= 2'd0;
            pend_wr_q  <= 1'b0;
            pend_rd_q  <= 1'b0;
            buf_wr_q   <= 1'b0;
            buf_rd_q   <= 1'b0;
            buf_cnt_q  <= 2'd0;
            instr_q    <= NOP_INSTR;
            pc_q       <= 32'd0;
            pc4_q      <= 32'd0;
            valid_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pend_pc_q[i]  <= 32'd0;
                buf_data_q[i] <= 32'd0;
                buf_pc_q[i]   <= 32'd0;
            end
        end else begin
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            buf_wr_q   <= buf_wr_d;
            buf_rd_q   <= buf_rd_d;
            buf_cnt_q  <= buf_cnt_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            // Pending-PC FIFO tracks every request, dropped or kept, in issue order.
            if (w_issue) begin
                pend_pc_q[pend_wr_q] <= fpc_q;
                pend_wr_q            <= ~pend_wr_q;
            end
            if (w_rsp) begin
                pend_rd_q <= ~pend_rd_q;
            end
            if (w_keep) begin
                buf_data_q[buf_wr_q] <= imem_rsp_data;
                buf_pc_q[buf_wr_q]   <= pend_pc_q[pend_rd_q];
            end
        end
    end

    assign Instr      = instr_q;
    assign PC         = pc_q;
    assign PC_plus_4  = pc4_q;
    assign InstrValid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Randomized scoreboard bench for fetch_stage with an in-bench
//           memory model and epoch-based reference of the fetch stream.
// Revision: 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] Instr, PC, PC_plus_4;
    logic        InstrValid;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .Instr(Instr), .PC(PC), .PC_plus_4(PC_plus_4), .InstrValid(InstrValid)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int tag; } req_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; int tag; } exp_t;

    req_t        memq[$];   // requests accepted by memory, not yet answered
    exp_t        sbq[$];    // instructions expected at decode, in order
    int          cyc = 0;
    int          epoch = 0;
    logic [31:0] fpc_m;
    int          pass_cnt = 0, chk_cnt = 0;

    // stimulus knobs
    bit          stall_k, flush_k, junk_k;
    logic [31:0] redir_k;
    int          ready_mode, rsp_mode;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + ((a - RST_PC) >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_valid"}, {31'd0, InstrValid}, 32'd0);
        chk({name, "_instr"}, Instr, NOP);
        chk({name, "_pc"}, PC, 32'd0);
        chk({name, "_pc4"}, PC_plus_4, 32'd0);
    endtask

    // Monitor: registered outputs, sampled 2 time units after each edge.
    initial begin
        logic [31:0] p_instr, p_pc, p_pc4;
        logic        p_v;
        exp_t        e;
        p_instr = NOP; p_pc = 0; p_pc4 = 0; p_v = 0;
        forever begin
            @(posedge clk);
            #2;
            if (reset === 1'b1) begin
                if (flush) begin
                    chk_bubble("flush_bubble");
                end else if (stall) begin
                    chk("stall_instr", Instr, p_instr);
                    chk("stall_pc", PC, p_pc);
                    chk("stall_pc4", PC_plus_4, p_pc4);
                    chk("stall_valid", {31'd0, InstrValid}, {31'd0, p_v});
                end else if (sbq.size() > 0 && sbq[0].tag < cyc) begin
                    e = sbq.pop_front();
                    chk("out_valid", {31'd0, InstrValid}, 32'd1);
                    chk("out_instr", Instr, e.data);
                    chk("out_pc", PC, e.pc);
                    chk("out_pc4", PC_plus_4, e.pc + 32'd4);
                end else begin
                    chk_bubble("idle_bubble");
                end
            end
            p_instr = Instr; p_pc = PC; p_pc4 = PC_plus_4; p_v = InstrValid;
        end
    end

    // One clock of stimulus: drive at negedge, then account for the coming edge.
    task automatic step();
        req_t r;
        bit   rsp;
        int   infl;
        exp_t e;
        @(negedge clk);
        stall       = stall_k;
        flush       = flush_k;
        redirect_pc = redir_k;
        case (ready_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = 1'($urandom_range(0, 1));
            default: imem_req_ready = 1'b0;
        endcase
        rsp  = 0;
        infl = memq.size();
        if (memq.size() > 0 && memq[0].tag <= cyc) begin
            if (rsp_mode == 0) rsp = 1;
            else if (rsp_mode == 1) rsp = ($urandom_range(0, 3) != 0);
        end
        if (rsp) begin
            r = memq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(r.addr);
        end else if (junk_k) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, (!flush_k && (infl + sbq.size() < 2))});
        if (imem_req_valid) chk("req_addr", imem_req_addr, fpc_m);
        if (rsp && r.epoch == epoch && !flush_k) begin
            e.data = mem_word(r.addr); e.pc = r.addr; e.tag = cyc + 1;
            sbq.push_back(e);
        end
        if (flush_k) begin
            epoch++;
            sbq.delete();
            fpc_m = redir_k & 32'hFFFF_FFFC;
        end else if (imem_req_valid && imem_req_ready) begin
            r.addr = fpc_m; r.epoch = epoch; r.tag = cyc + 1;
            memq.push_back(r);
            fpc_m = fpc_m + 32'd4;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic knobs(input bit s, input bit f, input logic [31:0] rd, input int rm, input int sm);
        stall_k = s; flush_k = f; redir_k = rd; ready_mode = rm; rsp_mode = sm;
    endtask

    initial begin
        reset = 1'b0; stall = 0; flush = 0; redirect_pc = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        junk_k = 0;
        fpc_m = RST_PC;
        knobs(0, 0, 0, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_instr", Instr, NOP);
        chk("rst_pc", PC, 32'd0);
        chk("rst_pc4", PC_plus_4, 32'd0);
        chk("rst_valid", {31'd0, InstrValid}, 32'd0);
        chk("rst_addr", imem_req_addr, RST_PC);
        #2 reset = 1'b1;

        // steady stream
        run(10);
        // stall mid-stream
        knobs(1, 0, 0, 0, 0); run(3);
        knobs(0, 0, 0, 0, 0); run(8);
        // build two in flight, then flush with a same-cycle stale response
        knobs(0, 0, 0, 0, 2); run(3);
        knobs(0, 1, 32'h203, 0, 0); run(1);
        knobs(0, 0, 0, 0, 0); run(8);
        // flush and stall together
        knobs(1, 1, 32'h400, 0, 0); run(1);
        knobs(0, 0, 0, 0, 0); run(6);
        // memory not ready for 5 cycles
        knobs(0, 0, 0, 2, 0); run(5);
        knobs(0, 0, 0, 0, 0); run(6);
        // address wrap
        knobs(0, 1, 32'hFFFF_FFF8, 0, 0); run(1);
        knobs(0, 0, 0, 0, 0); run(8);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            knobs($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom, 1, 1);
            step();
        end
        knobs(0, 0, 0, 0, 0); run(6);

        // asynchronous reset mid-burst
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("arst_instr", Instr, NOP);
        chk("arst_pc", PC, 32'd0);
        chk("arst_pc4", PC_plus_4, 32'd0);
        chk("arst_valid", {31'd0, InstrValid}, 32'd0);
        memq.delete(); sbq.delete(); fpc_m = RST_PC; epoch++;
        imem_rsp_valid = 0; stall = 0; flush = 0; imem_req_ready = 0;
        @(posedge clk); #3;
        reset = 1'b1;
        junk_k = 1; knobs(0, 0, 0, 0, 0); run(1);
        junk_k = 0; run(10);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
